// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bundle between the core and the PC sequencer
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic [XLEN-1:0] trap_pc;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            misalign_trap;
  logic [1:0]      state;

  modport master (
    output stall, redirect_valid, redirect_target, trap_req, trap_pc, mret, halt_req, resume,
    input  pc, pc_valid, epc, misalign_trap, state
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_req, trap_pc, mret, halt_req, resume,
    output pc, pc_valid, epc, misalign_trap, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with boot delay, redirect, trap and debug halt
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              INSN_BYTES   = 4,
  parameter int              BOOT_CYCLES  = 2
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam state_t          RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
  localparam logic [3:0]      BOOT_LAST   = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = XLEN'(INSN_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(INSN_BYTES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // pc only moves once it has been presented as a live fetch address
        if (valid_q) begin
          if (bus.trap_req) begin
            pc_d  = TRAP_VECTOR;
            epc_d = bus.trap_pc;
          end else if (bus.mret) begin
            pc_d = epc_q;
          end else if (bus.redirect_valid) begin
            if ((bus.redirect_target & ALIGN_MASK) != '0) begin
              pc_d  = TRAP_VECTOR;
              epc_d = bus.redirect_target;
              mis_d = 1'b1;
            end else begin
              pc_d = bus.redirect_target;
            end
          end else if (!bus.stall) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        if (bus.halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (bus.resume) state_d = ST_RUN;
      end
      default: state_d = RESET_STATE;
    endcase
    valid_d = (state_d == ST_RUN);
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = valid_q;
  assign bus.epc           = epc_q;
  assign bus.misalign_trap = mis_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural fetch model
module tb_pc_sequencer;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;
  localparam int          INSN  = 4;
  localparam int          BOOT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSN_BYTES(INSN), .BOOT_CYCLES(BOOT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        mis;
    logic [31:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;

  // Model: mode 0 boot, 1 run, 2 halt; boot_left counts boot cycles still to spend
  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  int          m_mode, m_boot_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.valid = (m_mode == 1);
    e.epc   = m_epc;
    e.mis   = m_mis;
    e.st    = m_mode;
    return e;
  endfunction

  task automatic model_reset();
    m_pc        = RV;
    m_epc       = 32'h0;
    m_mis       = 1'b0;
    m_mode      = (BOOT == 0) ? 1 : 0;
    m_boot_left = BOOT;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rt,
                            input logic tr, input logic [31:0] tp, input logic mr,
                            input logic hr, input logic rs);
    m_mis = 1'b0;
    if (m_mode == 0) begin
      m_boot_left = m_boot_left - 1;
      if (m_boot_left <= 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (tr) begin
        m_pc = TV; m_epc = tp;
      end else if (mr) begin
        m_pc = m_epc;
      end else if (rv && (rt % INSN) != 0) begin
        m_pc = TV; m_epc = rt; m_mis = 1'b1;
      end else if (rv) begin
        m_pc = rt;
      end else if (!st) begin
        m_pc = 32'((64'(m_pc) + INSN) % 64'h1_0000_0000);
      end
      if (hr) m_mode = 2;
    end else if (rs) begin
      m_mode = 1;
    end
  endtask

  task automatic cycle(input logic st, input logic rv, input logic [31:0] rt,
                       input logic tr, input logic [31:0] tp, input logic mr,
                       input logic hr, input logic rs);
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_target = rt;
    bus.trap_req = tr; bus.trap_pc = tp; bus.mret = mr;
    bus.halt_req = hr; bus.resume = rs;
    model_step(st, rv, rt, tr, tp, mr, hr, rs);
    exp_q.push_back(snapshot());
    pushed++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0; bus.trap_req = 0;
    bus.trap_pc = 0; bus.mret = 0; bus.halt_req = 0; bus.resume = 0;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, RV);
    chk("async_rst_state", 32'(bus.state), 32'd0);
    chk("async_rst_valid", 32'(bus.pc_valid), 32'd0);
    chk("async_rst_epc", bus.epc, 32'h0);
    chk("async_rst_mis", 32'(bus.misalign_trap), 32'd0);
    model_reset();
    exp_q.push_back(snapshot());
    pushed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("pc", bus.pc, e.pc);
        chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
        chk("epc", bus.epc, e.epc);
        chk("misalign_trap", 32'(bus.misalign_trap), 32'(e.mis));
        chk("state", 32'(bus.state), e.st);
      end
    end
  end

  initial begin : driver
    logic        st, rv, tr, mr, hr, rs;
    logic [31:0] rt, tp;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0; bus.trap_req = 0;
    bus.trap_pc = 0; bus.mret = 0; bus.halt_req = 0; bus.resume = 0;
    @(negedge clk);
    do_reset();
    idle(5);
    cycle(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    cycle(1, 1, 32'h40, 0, 32'h0, 0, 0, 0);
    idle(1);
    cycle(0, 1, 32'h52, 0, 32'h0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
    cycle(0, 1, 32'h80, 1, 32'h20, 1, 0, 0);
    cycle(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 32'h60, 0, 32'h0, 0, 1, 0);
    cycle(0, 0, 32'h0, 1, 32'h44, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 32'h0, 0, 1, 1);
    idle(1);
    cycle(0, 0, 32'h0, 0, 32'h0, 0, 1, 0);
    idle(2);
    do_reset();
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 3) == 0);
        rv = ($urandom_range(0, 5) == 0);
        rt = $urandom;
        if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
        tr = ($urandom_range(0, 15) == 0);
        tp = $urandom;
        mr = ($urandom_range(0, 11) == 0);
        hr = ($urandom_range(0, 24) == 0);
        rs = ($urandom_range(0, 3) == 0);
        cycle(st, rv, rt, tr, tp, mr, hr, rs);
      end
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
